// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 control/sequencer slice.
// Contents: opcode constants, one-hot ring states T1..T6, and the bit
// indices used to pack the control word inside the sequencer.
package sap1_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [5:0] {
    ST_T1 = 6'b000001,
    ST_T2 = 6'b000010,
    ST_T3 = 6'b000100,
    ST_T4 = 6'b001000,
    ST_T5 = 6'b010000,
    ST_T6 = 6'b100000
  } ring_t;

  localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_JMP = 4'b0011;
  localparam logic [OP_W-1:0] OP_JZ  = 4'b0100;
  localparam logic [OP_W-1:0] OP_JC  = 4'b0101;
  localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  localparam int unsigned CW_CP = 0;
  localparam int unsigned CW_EP = 1;
  localparam int unsigned CW_EJ = 2;
  localparam int unsigned CW_LM = 3;
  localparam int unsigned CW_ER = 4;
  localparam int unsigned CW_LI = 5;
  localparam int unsigned CW_EI = 6;
  localparam int unsigned CW_LA = 7;
  localparam int unsigned CW_EA = 8;
  localparam int unsigned CW_SU = 9;
  localparam int unsigned CW_EU = 10;
  localparam int unsigned CW_LB = 11;
  localparam int unsigned CW_LO = 12;
  localparam int unsigned CW_W  = 13;

endpackage

// File: rtl/controlador_sequenciador_anel_temporizador.sv
// anel_temporizador: 6-bit one-hot ring counter T1..T6.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (state -> T1)
//   freeze - hold current state (used while halted)
//   ring   - one-hot state, ring[0]=T1 .. ring[5]=T6
// The first edge after reset release only arms the counter, so T1 is
// held for one full cycle before the ring starts advancing.
module anel_temporizador
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       freeze,
  output logic [5:0] ring
);

  ring_t st;
  ring_t st_next;
  logic  armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= ST_T1;
      armed <= 1'b0;
    end else if (!armed) begin
      armed <= 1'b1;
    end else if (!freeze) begin
      st <= st_next;
    end
  end

  always_comb begin
    st_next = ST_T1;
    unique case (st)
      ST_T1:   st_next = ST_T2;
      ST_T2:   st_next = ST_T3;
      ST_T3:   st_next = ST_T4;
      ST_T4:   st_next = ST_T5;
      ST_T5:   st_next = ST_T6;
      ST_T6:   st_next = ST_T1;
      default: st_next = ST_T1;
    endcase
  end

  assign ring = st;

endmodule

// File: rtl/controlador_sequenciador.sv
// controlador_sequenciador: SAP-1 control/sequencer.
// Steps the T1..T6 ring and decodes Opcode into the one-hot control word.
// Ports:
//   CLK, CLR (async active-low reset), Opcode (from IR), Z, C (flags)
//   Cp, Ep, Ej, Lm, Er, Li, Ei, La, Ea, Su, Eu, Lb, Lo - control word
//   HLT - halted indicator; T - one-hot ring state (zero in reset/HALT)
// Build option: define COND_JUMP_EN to enable JZ (0100) and JC (0101).
module controlador_sequenciador
  import sap1_pkg::*;
#(
  parameter int unsigned OP_W = 4
)
(
  input  logic            CLK,
  input  logic            CLR,
  input  logic [OP_W-1:0] Opcode,
  input  logic            Z,
  input  logic            C,
  output logic            Cp,
  output logic            Ep,
  output logic            Ej,
  output logic            Lm,
  output logic            Er,
  output logic            Li,
  output logic            Ei,
  output logic            La,
  output logic            Ea,
  output logic            Su,
  output logic            Eu,
  output logic            Lb,
  output logic            Lo,
  output logic            HLT,
  output logic [5:0]      T
);

  logic [5:0]      ring;
  ring_t           st;
  logic            halted;
  logic [CW_W-1:0] cw;

  anel_temporizador u_anel (
    .clk    (CLK),
    .rst_n  (CLR),
    .freeze (halted),
    .ring   (ring)
  );

  assign st = ring_t'(ring);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      halted <= 1'b0;
    end else if (st == ST_T4 && Opcode == OP_HLT) begin
      halted <= 1'b1;
    end
  end

  always_comb begin
    cw = '0;
    unique case (st)
      ST_T1: begin
        cw[CW_EP] = 1'b1;
        cw[CW_LM] = 1'b1;
      end
      ST_T2: cw[CW_CP] = 1'b1;
      ST_T3: begin
        cw[CW_ER] = 1'b1;
        cw[CW_LI] = 1'b1;
      end
      ST_T4: begin
        case (Opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw[CW_EI] = 1'b1;
            cw[CW_LM] = 1'b1;
          end
          OP_JMP: begin
            cw[CW_EI] = 1'b1;
            cw[CW_EJ] = 1'b1;
          end
          OP_OUT: begin
            cw[CW_EA] = 1'b1;
            cw[CW_LO] = 1'b1;
          end
`ifdef COND_JUMP_EN
          OP_JZ: begin
            cw[CW_EI] = Z;
            cw[CW_EJ] = Z;
          end
          OP_JC: begin
            cw[CW_EI] = C;
            cw[CW_EJ] = C;
          end
`endif
          default: cw = '0;
        endcase
      end
      ST_T5: begin
        case (Opcode)
          OP_LDA: begin
            cw[CW_ER] = 1'b1;
            cw[CW_LA] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_ER] = 1'b1;
            cw[CW_LB] = 1'b1;
            cw[CW_SU] = (Opcode == OP_SUB);
          end
          default: cw = '0;
        endcase
      end
      ST_T6: begin
        if (Opcode == OP_ADD || Opcode == OP_SUB) begin
          cw[CW_EU] = 1'b1;
          cw[CW_LA] = 1'b1;
          cw[CW_SU] = (Opcode == OP_SUB);
        end
      end
      default: cw = '0;
    endcase
    // Reset and HALT both silence the bus regardless of ring contents.
    if (halted || !CLR) begin
      cw = '0;
    end
  end

`ifndef COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = Z ^ C;
`endif

  assign Cp  = cw[CW_CP];
  assign Ep  = cw[CW_EP];
  assign Ej  = cw[CW_EJ];
  assign Lm  = cw[CW_LM];
  assign Er  = cw[CW_ER];
  assign Li  = cw[CW_LI];
  assign Ei  = cw[CW_EI];
  assign La  = cw[CW_LA];
  assign Ea  = cw[CW_EA];
  assign Su  = cw[CW_SU];
  assign Eu  = cw[CW_EU];
  assign Lb  = cw[CW_LB];
  assign Lo  = cw[CW_LO];
  assign HLT = halted;
  assign T   = (halted || !CLR) ? '0 : ring;

endmodule

// File: tb/tb_controlador_sequenciador.sv
// Scoreboard bench for controlador_sequenciador: a driver applies inputs
// after each rising edge and pushes the expected outputs; a monitor pops
// and compares on the falling edge.
module tb_controlador_sequenciador;

  logic       CLK;
  logic       CLR;
  logic [3:0] Opcode;
  logic       Z;
  logic       C;
  logic       Cp, Ep, Ej, Lm, Er, Li, Ei, La, Ea, Su, Eu, Lb, Lo, HLT;
  logic [5:0] T;

  controlador_sequenciador #(.OP_W(4)) dut (
    .CLK(CLK), .CLR(CLR), .Opcode(Opcode), .Z(Z), .C(C),
    .Cp(Cp), .Ep(Ep), .Ej(Ej), .Lm(Lm), .Er(Er), .Li(Li), .Ei(Ei),
    .La(La), .Ea(Ea), .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo), .HLT(HLT), .T(T)
  );

  // Packing: {Cp,Ep,Ej,Lm,Er,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
  localparam logic [12:0] M_CP = 13'h1000;
  localparam logic [12:0] M_EP = 13'h0800;
  localparam logic [12:0] M_EJ = 13'h0400;
  localparam logic [12:0] M_LM = 13'h0200;
  localparam logic [12:0] M_ER = 13'h0100;
  localparam logic [12:0] M_LI = 13'h0080;
  localparam logic [12:0] M_EI = 13'h0040;
  localparam logic [12:0] M_LA = 13'h0020;
  localparam logic [12:0] M_EA = 13'h0010;
  localparam logic [12:0] M_SU = 13'h0008;
  localparam logic [12:0] M_EU = 13'h0004;
  localparam logic [12:0] M_LB = 13'h0002;
  localparam logic [12:0] M_LO = 13'h0001;

  typedef struct {
    logic [19:0] v;   // {ctrl[12:0], HLT, T[5:0]}
    string       tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: instruction step 0..5, arming flag, halt flag.
  int  mstep = 0;
  bit  marmed = 0;
  bit  mhalt = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [12:0] micro(input int step, input logic [3:0] op,
                                        input logic z, input logic c);
    logic [12:0] ex4, ex5, ex6;
    bit cond;
    ex4 = '0; ex5 = '0; ex6 = '0;
    case (op)
      4'd0:  begin ex4 = M_EI | M_LM; ex5 = M_ER | M_LA; end
      4'd1:  begin ex4 = M_EI | M_LM; ex5 = M_ER | M_LB; ex6 = M_EU | M_LA; end
      4'd2:  begin ex4 = M_EI | M_LM; ex5 = M_ER | M_LB | M_SU; ex6 = M_EU | M_LA | M_SU; end
      4'd3:  ex4 = M_EI | M_EJ;
      4'd14: ex4 = M_EA | M_LO;
      4'd4, 4'd5: begin
`ifdef COND_JUMP_EN
        cond = (op == 4'd4) ? z : c;
`else
        cond = 1'b0;
`endif
        if (cond) ex4 = M_EI | M_EJ;
      end
      default: ;
    endcase
    case (step)
      0: return M_EP | M_LM;
      1: return M_CP;
      2: return M_ER | M_LI;
      3: return ex4;
      4: return ex5;
      default: return ex6;
    endcase
  endfunction

  function automatic logic [19:0] expect_now(input logic [3:0] op, input logic z,
                                             input logic c, input logic clr);
    logic [5:0] tv;
    if (!clr) return '0;
    if (mhalt) return {13'b0, 1'b1, 6'b0};
    tv = 6'b1 << mstep;
    return {micro(mstep, op, z, c), 1'b0, tv};
  endfunction

  // One clock: advance the model at the edge, then drive new inputs.
  task automatic cycle(input logic clr, input logic [3:0] op, input logic z,
                       input logic c, input string tag);
    exp_t e;
    @(posedge CLK);
    if (CLR) begin
      if (!marmed) marmed = 1;
      else if (!mhalt) begin
        if (mstep == 3 && Opcode == 4'hF) mhalt = 1;
        else mstep = (mstep + 1) % 6;
      end
    end
    #1;
    if (!clr) begin
      mstep = 0; marmed = 0; mhalt = 0;
    end
    CLR = clr; Opcode = op; Z = z; C = c;
    e.v = expect_now(op, z, c, clr);
    e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t       e;
    logic [19:0] act;
    int          nbus;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {Cp, Ep, Ej, Lm, Er, Li, Ei, La, Ea, Su, Eu, Lb, Lo, HLT, T};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got %b required %b", e.tag, act, e.v);
        end
        nbus = int'(Ep) + int'(Er) + int'(Ei) + int'(Ea) + int'(Eu);
        checks++;
        if (nbus > 1) begin
          errors++;
          $display("FAIL bus_unique(%s): got %0d enables required <=1", e.tag, nbus);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    CLR = 1'b0; Opcode = '0; Z = 1'b0; C = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0, "reset");
    for (int i = 0; i < 14; i++) cycle(1'b1, 4'h0, 1'b0, 1'b0, "lda");
    for (int i = 0; i < 6; i++)  cycle(1'b1, 4'h1, 1'b0, 1'b0, "add");
    for (int i = 0; i < 6; i++)  cycle(1'b1, 4'h2, 1'b0, 1'b0, "sub");
    for (int i = 0; i < 6; i++)  cycle(1'b1, 4'h3, 1'b0, 1'b0, "jmp");
    for (int i = 0; i < 6; i++)  cycle(1'b1, 4'hE, 1'b0, 1'b0, "out");
    for (int i = 0; i < 6; i++)  cycle(1'b1, 4'h4, 1'b0, 1'b1, "jz_z0");
    for (int i = 0; i < 6; i++)  cycle(1'b1, 4'h4, 1'b1, 1'b0, "jz_z1");
    for (int i = 0; i < 6; i++)  cycle(1'b1, 4'h5, 1'b0, 1'b1, "jc_c1");
    for (int i = 0; i < 6; i++)  cycle(1'b1, 4'h5, 1'b1, 1'b0, "jc_c0");
    // Reset in the middle of T3
    guard = 0;
    while (mstep != 2 && guard < 12) begin
      cycle(1'b1, 4'h1, 1'b0, 1'b0, "pre_t3");
      guard++;
    end
    checks++;
    if (mstep != 2) begin
      errors++;
      $display("FAIL reach_t3: got step %0d required 2", mstep);
    end
    for (int i = 0; i < 2; i++) cycle(1'b0, 4'h1, 1'b0, 1'b0, "reset_mid");
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'h1, 1'b0, 1'b0, "post_reset");
    // Random opcodes (HALT excluded so the ring keeps running)
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      cycle(1'b1, op, 1'($urandom), 1'($urandom), "random");
    end
    // Halt and hold
    for (int i = 0; i < 30; i++) cycle(1'b1, 4'hF, 1'b0, 1'b0, "halt");
    checks++;
    if (!mhalt) begin
      errors++;
      $display("FAIL halt_reached: got model halt %0d required 1", mhalt);
    end
    for (int i = 0; i < 2; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0, "halt_clear");
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'h0, 1'b0, 1'b0, "after_halt");
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge CLK);
      guard++;
    end
    @(posedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
